// File: rtl/vec_spi_rx_pkg.sv
// Shared constants for the view-vector SPI receiver: vector geometry, counter width
// and the power-on camera state.
package vec_spi_rx_pkg;

  localparam int unsigned VEC_W      = 16;
  localparam int unsigned NVEC       = 6;
  localparam int unsigned FRAME_BITS = NVEC * VEC_W;
  // Counter must reach FRAME_BITS+1 so an over-long frame stays distinguishable.
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 2);

  localparam logic [VEC_W-1:0] RST_PX = 16'h0A00;
  localparam logic [VEC_W-1:0] RST_PY = 16'h0A00;
  localparam logic [VEC_W-1:0] RST_FX = 16'h0000;
  localparam logic [VEC_W-1:0] RST_FY = 16'h0400;
  localparam logic [VEC_W-1:0] RST_VX = 16'hFE00;
  localparam logic [VEC_W-1:0] RST_VY = 16'h0000;

  function automatic logic [FRAME_BITS-1:0] rst_frame();
    return {RST_PX, RST_PY, RST_FX, RST_FY, RST_VX, RST_VY};
  endfunction

endpackage

// File: rtl/vec_spi_rx_if.sv
// SPI peripheral pin bundle; the SoC side drives it, the receiver only samples it.
interface vec_spi_rx_if;

  logic csb;
  logic sclk;
  logic mosi;

  modport master (output csb, output sclk, output mosi);
  modport slave  (input  csb, input  sclk, input  mosi);

endinterface

// File: rtl/vec_spi_rx_sync2.sv
// Two-flop synchronizer with a configurable idle (reset) value per bit.
module sync2 #(
  parameter int unsigned       Width    = 1,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_d, meta_q;
  logic [Width-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/vec_spi_rx.sv
// Receives 96-bit camera-vector frames over SPI and commits them to the outputs
// only at the vertical-blanking boundary, so a frame never tears mid-render.
module vec_spi_rx #(
  parameter int unsigned VEC_W = vec_spi_rx_pkg::VEC_W,
  parameter int unsigned NVEC  = vec_spi_rx_pkg::NVEC
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_la_invalid,
  vec_spi_rx_if.slave       spi,
  input  logic              i_frame_end,
  output logic [VEC_W-1:0]  o_px,
  output logic [VEC_W-1:0]  o_py,
  output logic [VEC_W-1:0]  o_fx,
  output logic [VEC_W-1:0]  o_fy,
  output logic [VEC_W-1:0]  o_vx,
  output logic [VEC_W-1:0]  o_vy,
  output logic              o_vec_updated,
  output logic              o_frame_err,
  output logic              o_busy
);

  import vec_spi_rx_pkg::*;

  localparam int unsigned     FrameW  = NVEC * VEC_W;
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(FrameW);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(FrameW + 1);

  logic [2:0] pins_s;
  logic       csb_s, sclk_s, mosi_s, csb_eff;

  sync2 #(
    .Width    (3),
    .ResetVal (3'b100)
  ) u_sync (
    .clk_i  (i_clk),
    .rst_ni (i_reset_n),
    .d_i    ({spi.csb, spi.sclk, spi.mosi}),
    .q_o    (pins_s)
  );

  assign csb_s   = pins_s[2];
  assign sclk_s  = pins_s[1];
  assign mosi_s  = pins_s[0];
  assign csb_eff = csb_s | i_la_invalid;

  logic              sclk_prev_d, sclk_prev_q;
  logic              csb_eff_d, csb_eff_q;
  logic              shift_d, shift_q;
  logic              mosi_d, mosi_q;
  logic              rise_d, rise_q;
  logic              fall_d, fall_q;
  logic              busy_d, busy_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [FrameW-1:0] shreg_d, shreg_q;
  logic [FrameW-1:0] pend_d, pend_q;
  logic              pend_valid_d, pend_valid_q;
  logic [FrameW-1:0] out_d, out_q;
  logic              upd_d, upd_q;
  logic              err_d, err_q;
  logic              load, commit;

  always_comb begin
    // Edge events are registered once more so data and CSB actions share one pipeline stage.
    sclk_prev_d = sclk_s;
    csb_eff_d   = csb_eff;
    shift_d     = sclk_s & ~sclk_prev_q & ~csb_eff;
    mosi_d      = mosi_s;
    rise_d      = csb_eff & ~csb_eff_q;
    fall_d      = ~csb_eff & csb_eff_q;
    busy_d      = ~csb_eff;

    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (fall_q) begin
      cnt_d   = '0;
      shreg_d = '0;
    end else if (shift_q) begin
      shreg_d = {shreg_q[FrameW-2:0], mosi_q};
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    load   = rise_q && (cnt_q == CntFull);
    err_d  = rise_q && (cnt_q != CntFull) && (cnt_q != '0);
    commit = i_frame_end && pend_valid_q;

    // Commit reads the old pending frame even when a new one lands in the same cycle.
    out_d        = commit ? pend_q : out_q;
    upd_d        = commit;
    pend_d       = load ? shreg_q : pend_q;
    pend_valid_d = load | (pend_valid_q & ~commit);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sclk_prev_q  <= 1'b0;
      csb_eff_q    <= 1'b1;
      shift_q      <= 1'b0;
      mosi_q       <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      shreg_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      out_q        <= rst_frame();
      upd_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sclk_prev_q  <= sclk_prev_d;
      csb_eff_q    <= csb_eff_d;
      shift_q      <= shift_d;
      mosi_q       <= mosi_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      out_q        <= out_d;
      upd_q        <= upd_d;
      err_q        <= err_d;
    end
  end

  assign o_px          = out_q[FrameW-1 -: VEC_W];
  assign o_py          = out_q[FrameW-1-VEC_W -: VEC_W];
  assign o_fx          = out_q[FrameW-1-2*VEC_W -: VEC_W];
  assign o_fy          = out_q[FrameW-1-3*VEC_W -: VEC_W];
  assign o_vx          = out_q[FrameW-1-4*VEC_W -: VEC_W];
  assign o_vy          = out_q[FrameW-1-5*VEC_W -: VEC_W];
  assign o_vec_updated = upd_q;
  assign o_frame_err   = err_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_vec_spi_rx.sv
// Directed bench for vec_spi_rx: frame reception, length errors, commit timing,
// last-wins, la_invalid abort and mid-frame reset.
module tb_vec_spi_rx;

  logic        clk = 1'b0;
  logic        reset_n, la_invalid, frame_end;
  logic [15:0] px, py, fx, fy, vx, vy;
  logic        vec_updated, frame_err, busy;

  always #5 clk = ~clk;

  vec_spi_rx_if spi_bus ();

  vec_spi_rx dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_la_invalid  (la_invalid),
    .spi           (spi_bus),
    .i_frame_end   (frame_end),
    .o_px          (px),
    .o_py          (py),
    .o_fx          (fx),
    .o_fy          (fy),
    .o_vx          (vx),
    .o_vy          (vy),
    .o_vec_updated (vec_updated),
    .o_frame_err   (frame_err),
    .o_busy        (busy)
  );

  localparam logic [95:0] RstFrm = {16'h0A00, 16'h0A00, 16'h0000, 16'h0400, 16'hFE00, 16'h0000};
  localparam logic [95:0] FrmF1  = {16'h0C00, 16'h0800, 16'h0400, 16'h0000, 16'h0000, 16'hFE00};
  localparam logic [95:0] FrmA   = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
  localparam logic [95:0] FrmB   = {16'hF00F, 16'h0FF0, 16'h3C3C, 16'hC3C3, 16'h5A5A, 16'hA5A5};
  localparam logic [95:0] FrmC   = {16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600};
  localparam logic [95:0] FrmD   = {16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 16'h1234, 16'hABCD};

  int checks  = 0;
  int errors  = 0;
  int err_cnt = 0;
  int upd_cnt = 0;

  logic [95:0] outs;
  assign outs = {px, py, fx, fy, vx, vy};

  always @(negedge clk) begin
    if (frame_err === 1'b1) err_cnt++;
    if (vec_updated === 1'b1) upd_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drops CSB and clocks data[n-1:0] out MSB first; leaves CSB low.
  task automatic spi_bits(input logic [127:0] data, input int n);
    spi_bus.csb = 1'b0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      spi_bus.mosi = data[i];
      tick(4);
      spi_bus.sclk = 1'b1;
      tick(4);
      spi_bus.sclk = 1'b0;
    end
    tick(4);
  endtask

  task automatic spi_end();
    spi_bus.csb = 1'b1;
    tick(8);
  endtask

  task automatic pulse_frame_end();
    frame_end = 1'b1;
    tick(1);
    frame_end = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    la_invalid   = 1'b0;
    frame_end    = 1'b0;
    spi_bus.csb  = 1'b1;
    spi_bus.sclk = 1'b0;
    spi_bus.mosi = 1'b0;
    tick(3);
    @(negedge clk);
    checks++;
    if (outs !== RstFrm) begin
      errors++; $display("FAIL reset_vectors got %h want %h", outs, RstFrm);
    end
    checks++;
    if ({busy, vec_updated, frame_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {busy, vec_updated, frame_err});
    end
    tick(1);
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_valid_frame();
    int e0 = err_cnt;
    int u0 = upd_cnt;
    spi_bits(FrmF1, 96);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_in_frame got %b want 1", busy);
    end
    tick(1);
    spi_end();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_after_frame got %b want 0", busy);
    end
    checks++;
    if (outs !== RstFrm) begin
      errors++; $display("FAIL no_commit_before_end got %h want %h", outs, RstFrm);
    end
    tick(1);
    frame_end = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== RstFrm || vec_updated !== 1'b0) begin
      errors++; $display("FAIL commit_too_early got %h/%b want %h/0", outs, vec_updated, RstFrm);
    end
    tick(1);
    frame_end = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== FrmF1 || vec_updated !== 1'b1) begin
      errors++; $display("FAIL commit_f1 got %h/%b want %h/1", outs, vec_updated, FrmF1);
    end
    tick(3);
    checks++;
    if (upd_cnt - u0 !== 1 || err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL f1_pulses got upd %0d err %0d want 1 0", upd_cnt - u0, err_cnt - e0);
    end
  endtask

  task automatic test_bad_lengths();
    int e0, u0;
    apply_reset();
    e0 = err_cnt;
    u0 = upd_cnt;
    spi_bits({32'h0, FrmF1}, 95);
    spi_end();
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++; $display("FAIL err_95 got %0d want 1", err_cnt - e0);
    end
    spi_bits({FrmF1, 1'b1}, 97);
    spi_end();
    checks++;
    if (err_cnt - e0 !== 2) begin
      errors++; $display("FAIL err_97 got %0d want 2", err_cnt - e0);
    end
    spi_bits(128'h0, 0);
    spi_end();
    checks++;
    if (err_cnt - e0 !== 2) begin
      errors++; $display("FAIL err_empty_csb got %0d want 2", err_cnt - e0);
    end
    pulse_frame_end();
    tick(2);
    checks++;
    if (outs !== RstFrm || upd_cnt - u0 !== 0) begin
      errors++;
      $display("FAIL bad_len_commit got %h/%0d want %h/0", outs, upd_cnt - u0, RstFrm);
    end
  endtask

  task automatic test_last_wins();
    int u0 = upd_cnt;
    spi_bits(FrmA, 96);
    spi_end();
    spi_bits(FrmB, 96);
    spi_end();
    pulse_frame_end();
    @(negedge clk);
    checks++;
    if (outs !== FrmB || vec_updated !== 1'b1) begin
      errors++; $display("FAIL last_wins got %h/%b want %h/1", outs, vec_updated, FrmB);
    end
    tick(2);
    pulse_frame_end();
    tick(3);
    checks++;
    if (upd_cnt - u0 !== 1 || outs !== FrmB) begin
      errors++;
      $display("FAIL empty_commit got %0d/%h want 1/%h", upd_cnt - u0, outs, FrmB);
    end
  endtask

  task automatic test_coincide();
    spi_bits(FrmA, 96);
    spi_end();
    spi_bits(FrmC, 96);
    // CSB rises here; the frame lands in pending on the 4th edge, which also samples frame_end.
    spi_bus.csb = 1'b1;
    tick(3);
    frame_end = 1'b1;
    tick(1);
    frame_end = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== FrmA || vec_updated !== 1'b1) begin
      errors++; $display("FAIL coincide_old got %h/%b want %h/1", outs, vec_updated, FrmA);
    end
    tick(4);
    checks++;
    if (outs !== FrmA) begin
      errors++; $display("FAIL coincide_hold got %h want %h", outs, FrmA);
    end
    pulse_frame_end();
    @(negedge clk);
    checks++;
    if (outs !== FrmC || vec_updated !== 1'b1) begin
      errors++; $display("FAIL coincide_new got %h/%b want %h/1", outs, vec_updated, FrmC);
    end
    tick(2);
  endtask

  task automatic test_la_invalid();
    int e0 = err_cnt;
    int u0 = upd_cnt;
    spi_bits(FrmD, 40);
    la_invalid = 1'b1;
    tick(4);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL la_abort got busy %b err %0d want 0 1", busy, err_cnt - e0);
    end
    for (int i = 0; i < 10; i++) begin
      spi_bus.mosi = i[0];
      tick(4);
      spi_bus.sclk = 1'b1;
      tick(4);
      spi_bus.sclk = 1'b0;
    end
    spi_bus.csb = 1'b1;
    tick(2);
    la_invalid = 1'b0;
    tick(6);
    pulse_frame_end();
    tick(3);
    checks++;
    if (err_cnt - e0 !== 1 || upd_cnt - u0 !== 0 || outs !== FrmC) begin
      errors++;
      $display("FAIL la_sclk_ignored got err %0d upd %0d out %h want 1 0 %h",
               err_cnt - e0, upd_cnt - u0, outs, FrmC);
    end
  endtask

  task automatic test_reset_midframe();
    int e0 = err_cnt;
    spi_bits(FrmA, 50);
    reset_n     = 1'b0;
    spi_bus.csb = 1'b1;
    tick(3);
    @(negedge clk);
    checks++;
    if (outs !== RstFrm || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset got %h/%b want %h/0", outs, busy, RstFrm);
    end
    tick(1);
    reset_n = 1'b1;
    tick(4);
    spi_bits(FrmD, 96);
    spi_end();
    checks++;
    if (err_cnt - e0 !== 0) begin
      errors++; $display("FAIL reset_no_err got %0d want 0", err_cnt - e0);
    end
    pulse_frame_end();
    @(negedge clk);
    checks++;
    if (outs !== FrmD || vec_updated !== 1'b1) begin
      errors++; $display("FAIL reset_commit got %h/%b want %h/1", outs, vec_updated, FrmD);
    end
    tick(2);
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_lengths();
    test_last_wins();
    test_coincide();
    test_la_invalid();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
